// File: rtl/youseios_pkg.sv
// Shared definitions for the page-loading path between the simulated HD and instruction memory.
// Holds FSM state codes, default geometry and the opcode field position.
package youseios_pkg;

    localparam int         PAGE_WORDS_DEFAULT = 64;
    localparam logic [5:0] END_OP_DEFAULT     = 6'h3F;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PRIME = 2'd1;
    localparam state_t ST_COPY  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic logic [5:0] opcode_of(input logic [31:0] i_word);
        return i_word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/hd_page_loader.sv
// Streams one program page from HD into an instruction-memory frame, one word per cycle,
// stopping at the page limit or after copying a program-terminator word.
module hd_page_loader
    import youseios_pkg::*;
#(
    parameter int         PAGE_WORDS = PAGE_WORDS_DEFAULT,
    parameter logic [5:0] END_OP     = END_OP_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [4:0]  i_pid,
    input  logic [31:0] i_hd_base,
    input  logic [31:0] i_page,
    output logic [31:0] o_hd_index,
    input  logic [31:0] i_hd_data,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_data,
    output logic        o_mem_write,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_words,
    output logic [4:0]  o_pid_out
);

    localparam int              KW     = $clog2(PAGE_WORDS);
    localparam logic [KW-1:0]   K_LAST = KW'(PAGE_WORDS - 1);

    state_t        r_state;
    logic [KW-1:0] r_k;
    logic [31:0]   r_base;
    logic [31:0]   r_page;
    logic [31:0]   r_hd_index;
    logic [31:0]   r_words;
    logic [4:0]    r_pid;

    logic          w_copy;
    logic          w_last;

    assign w_copy = (r_state == ST_COPY);
    // Page limit and terminator share one exit; the terminator word itself is still written.
    assign w_last = (r_k == K_LAST) || (opcode_of(i_hd_data) == END_OP);

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_base     <= '0;
            r_page     <= '0;
            r_hd_index <= '0;
            r_words    <= '0;
            r_pid      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_pid      <= i_pid;
                        r_base     <= i_hd_base;
                        r_page     <= i_page;
                        r_hd_index <= i_hd_base;
                        r_k        <= '0;
                        r_words    <= '0;
                        r_state    <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    r_hd_index <= r_base + 32'd1;
                    r_state    <= ST_COPY;
                end
                ST_COPY: begin
                    // Fetch runs two words ahead of the write because HD data lags its index by a cycle.
                    r_hd_index <= r_base + 32'(r_k) + 32'd2;
                    r_words    <= 32'(r_k) + 32'd1;
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_hd_index    = r_hd_index;
    assign o_mem_write   = w_copy;
    assign o_mem_address = w_copy ? ((r_page << KW) + 32'(r_k)) : '0;
    assign o_mem_data    = w_copy ? i_hd_data : '0;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_DONE);
    assign o_words       = r_words;
    assign o_pid_out     = r_pid;

endmodule

// File: tb/tb_hd_page_loader.sv
// Self-checking bench for hd_page_loader: a registered-read HD model feeds the loader and
// every instruction-memory write is compared against a page-copy reference model.
module tb_hd_page_loader;
    import youseios_pkg::*;

    localparam int PW      = 64;
    localparam int HD_SIZE = 1024;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic [4:0]  pid     = '0;
    logic [31:0] hd_base = '0;
    logic [31:0] page    = '0;
    logic [31:0] hd_data;
    logic [31:0] hd_index;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_write;
    logic        busy;
    logic        done;
    logic [31:0] words;
    logic [4:0]  pid_out;

    logic [31:0] hd_mem [HD_SIZE];

    int n_cmp  = 0;
    int n_fail = 0;

    hd_page_loader #(.PAGE_WORDS(PW), .END_OP(6'h3F)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_pid         (pid),
        .i_hd_base     (hd_base),
        .i_page        (page),
        .o_hd_index    (hd_index),
        .i_hd_data     (hd_data),
        .o_mem_address (mem_address),
        .o_mem_data    (mem_data),
        .o_mem_write   (mem_write),
        .o_busy        (busy),
        .o_done        (done),
        .o_words       (words),
        .o_pid_out     (pid_out)
    );

    always #5 clk = ~clk;

    // HD returns the word one cycle after its index is presented.
    always @(posedge clk) hd_data <= hd_mem[hd_index[9:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic plant_terminator(input int idx);
        hd_mem[idx][31:26] = 6'h3F;
    endtask

    // Runs one load; poke_m > 0 raises Start with another PID for one cycle at that point.
    task automatic do_load(input logic [4:0] l_pid, input logic [31:0] l_base,
                           input logic [31:0] l_page, input int poke_m, input string tag);
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        logic [31:0] a;
        logic [31:0] w;
        int nw;
        int wi;
        int done_m;
        int done_cnt;
        for (int k = 0; k < PW; k++) begin
            a = l_base + 32'(k);
            w = hd_mem[a[9:0]];
            ea.push_back(l_page * 32'(PW) + 32'(k));
            ed.push_back(w);
            if (w[31:26] == 6'h3F) break;
        end
        nw = ea.size();
        @(negedge clk);
        start = 1'b1; pid = l_pid; hd_base = l_base; page = l_page;
        @(negedge clk);
        start = 1'b0; pid = ~l_pid; hd_base = $urandom; page = $urandom;
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        check({tag, " pid latched"}, 32'(pid_out), 32'(l_pid));
        wi = 0; done_m = -1; done_cnt = 0;
        for (int m = 1; m < PW + 8; m++) begin
            @(negedge clk);
            if (poke_m > 0 && m == poke_m + 1) start = 1'b0;
            if (mem_write) begin
                if (wi < nw) begin
                    check({tag, " addr"}, mem_address, ea[wi]);
                    check({tag, " data"}, mem_data, ed[wi]);
                    check({tag, " write cycle"}, 32'(m), 32'(wi + 1));
                end
                wi++;
            end
            if (done) begin
                done_cnt++;
                if (done_m < 0) done_m = m;
            end
            if (m == poke_m) begin
                start = 1'b1; pid = l_pid + 5'd1;
            end
            if (done_m >= 0 && m >= done_m + 3) break;
        end
        check({tag, " write count"}, 32'(wi), 32'(nw));
        check({tag, " done cycle"}, 32'(done_m), 32'(nw + 1));
        check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " words"}, words, 32'(nw));
        check({tag, " pid held"}, 32'(pid_out), 32'(l_pid));
        check({tag, " idle after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] rb;
        for (int i = 0; i < HD_SIZE; i++) begin
            hd_mem[i] = $urandom;
            if (hd_mem[i][31:26] == 6'h3F) hd_mem[i][26] = 1'b0;
        end
        plant_terminator(5);
        plant_terminator(263);

        repeat (3) @(negedge clk);
        check("rst hd_index", hd_index, 32'd0);
        check("rst mem_address", mem_address, 32'd0);
        check("rst mem_data", mem_data, 32'd0);
        check("rst mem_write", 32'(mem_write), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst words", words, 32'd0);
        check("rst pid_out", 32'(pid_out), 32'd0);
        reset = 1'b0;

        do_load(5'd3, 32'd100, 32'd3, 0, "full");
        do_load(5'd4, 32'd0, 32'd1, 0, "term5");
        do_load(5'd6, 32'd200, 32'd7, 0, "term_last");
        do_load(5'd7, 32'd300, 32'd9, 20, "poke");

        // Reset in the middle of a copy.
        @(negedge clk);
        start = 1'b1; pid = 5'd9; hd_base = 32'd300; page = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid words before reset", words, 32'd8);
        check("mid writing before reset", 32'(mem_write), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid mem_write", 32'(mem_write), 32'd0);
        check("mid busy", 32'(busy), 32'd0);
        seen = 0;
        for (int m = 0; m < PW + 4; m++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("mid no done", 32'(seen), 32'd0);
        do_load(5'd10, 32'd300, 32'd2, 0, "after_reset");

        // Start held high across two full-page loads.
        @(negedge clk);
        start = 1'b1; pid = 5'd1; hd_base = 32'd400; page = 32'd5;
        @(negedge clk);
        pid = 5'd2;
        check("b2b first pid", 32'(pid_out), 32'd1);
        for (int m = 1; m <= PW + 3; m++) begin
            @(negedge clk);
            if (m == PW + 1) check("b2b done", 32'(done), 32'd1);
            if (m == PW + 2) begin
                check("b2b idle gap", 32'(busy), 32'd0);
                check("b2b pid before", 32'(pid_out), 32'd1);
            end
            if (m == PW + 3) begin
                check("b2b second busy", 32'(busy), 32'd1);
                check("b2b pid after", 32'(pid_out), 32'd2);
            end
        end
        start = 1'b0;
        seen = 0;
        for (int m = 0; m < PW + 4 && seen == 0; m++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("b2b second done", 32'(seen), 32'd1);
        check("b2b second words", words, 32'(PW));

        // Random loads with an optional terminator somewhere in the page.
        for (int r = 0; r < 4; r++) begin
            rb = 32'($urandom_range(500, 900));
            if ($urandom_range(0, 1) == 1) plant_terminator(int'(rb) + int'($urandom_range(0, PW - 1)));
            do_load(5'($urandom), rb, $urandom, 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
